fetch_buf: RTL and testbench

- Instruction-fetch stage with a small decoupling instruction queue.
- Drives the icache (1-cycle read latency) with a sequential PC and buffers returned words with their PCs.
- Presents {pc, instr} to the fetch-to-decode skid buffer via valid/ready.
- Redirects to a new PC on flush, discarding all queued and in-flight fetches.

---
 rtl/fetch_buf.sv | 113 +++++++++++
 tb/tb_fetch_buf.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buf.sv
// Instruction-fetch stage: sequential PC generator driving a 1-cycle icache,
// with a small circular queue decoupling fetch from the decode skid buffer.

package fetch_buf_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;
endpackage

module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [31:0]               flush_pc_i,
  input  logic                      ready_in,
  output logic                      valid_out,
  output logic [31:0]               pc_out,
  output logic [31:0]               instr_out,
  output logic                      icache_en_o,
  output logic [31:0]               icache_addr_o,
  input  logic [31:0]               icache_rdata_i,
  input  logic                      icache_rvalid_i,
  output logic [$clog2(FQ_DEPTH):0] occupancy_o
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic             req_v_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  fq_entry_t        mem_q [FQ_DEPTH];

  logic             enq;
  logic             deq;
  logic [SUM_W-1:0] credit_used;
  fq_entry_t        head_entry;

  // Credit check counts queued entries plus the in-flight request; a
  // same-cycle dequeue is deliberately not credited.
  always_comb begin
    credit_used   = SUM_W'(count_q) + SUM_W'(req_v_q);
    icache_en_o   = rst_n & ~flush_i & (credit_used < SUM_W'(FQ_DEPTH));
    icache_addr_o = pc_q;
  end

  // Responses with no matching request (stale or flushed) are dropped.
  always_comb begin
    enq = rst_n & ~flush_i & icache_rvalid_i & req_v_q;
    deq = valid_out & ready_in;
  end

  always_comb begin
    head_entry  = mem_q[head_q];
    valid_out   = rst_n & ~flush_i & (count_q != '0);
    pc_out      = head_entry.pc;
    instr_out   = head_entry.instr;
    occupancy_o = rst_n ? count_q : '0;
  end

  // Control state: flush outranks every other update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_v_q  <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      pc_q    <= {flush_pc_i[31:2], 2'b00};
      req_v_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      req_v_q <= icache_en_o;
      if (icache_en_o) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (deq) head_q <= head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= '{pc: req_pc_q, instr: icache_rdata_i};
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    enq |-> (count_q < CNT_W'(FQ_DEPTH)))
    else $error("fetch_buf: enqueue into full queue");

endmodule

// File: tb/tb_fetch_buf.sv
// Scoreboard bench for fetch_buf: icache model returns addr ^ 32'hA5A5_0000
// one cycle after each request; a monitor checks order, payload and stability.
`timescale 1ns/1ps
module tb_fetch_buf;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        ready = 1'b0;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic [2:0]  occ;

  logic        rv_q = 1'b0;
  logic [31:0] rd_q = 32'h0;
  logic        inj = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int pops  = 0;

  logic [63:0] sbq[$];
  logic [63:0] exp_e;
  logic [31:0] exp_fpc = 32'h0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_d = 64'h0;

  always #5 clk = ~clk;

  fetch_buf #(.FQ_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .flush_pc_i     (flush_pc),
    .ready_in       (ready),
    .valid_out      (valid_out),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .icache_en_o    (ic_en),
    .icache_addr_o  (ic_addr),
    .icache_rdata_i (ic_rdata),
    .icache_rvalid_i(ic_rvalid),
    .occupancy_o    (occ)
  );

  // icache: fixed 1-cycle latency; inj forces a spurious response
  always @(posedge clk) begin
    rv_q <= ic_en;
    rd_q <= ic_addr ^ XORK;
  end
  assign ic_rvalid = rv_q | inj;
  assign ic_rdata  = inj ? 32'hDEAD_BEEF : rd_q;

  // Monitor: predict fetch PCs, queue expected deliveries, compare on pop
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      sbq.delete();
      exp_fpc = 32'h0;
    end else if (flush) begin
      sbq.delete();
      exp_fpc = {flush_pc[31:2], 2'b00};
    end else begin
      if (hold_v) begin
        n_vec++;
        if (valid_out !== 1'b1 || {pc_out, instr_out} !== hold_d) begin
          n_bad++;
          $display("FAIL hold_stable: valid=%b got=%h want=%h", valid_out, {pc_out, instr_out}, hold_d);
        end
      end
      if (valid_out === 1'b1 && ready === 1'b1) begin
        n_vec++;
        pops++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, want nothing", pc_out, instr_out);
        end else begin
          exp_e = sbq.pop_front();
          if ({pc_out, instr_out} !== exp_e) begin
            n_bad++;
            $display("FAIL sb_data: got %h, want %h", {pc_out, instr_out}, exp_e);
          end
        end
      end
      if (ic_en === 1'b1) begin
        n_vec++;
        if (ic_addr !== exp_fpc) begin
          n_bad++;
          $display("FAIL sb_fetch_addr: got %h, want %h", ic_addr, exp_fpc);
        end
        sbq.push_back({exp_fpc, exp_fpc ^ XORK});
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    n_vec++;
    if (occ > 3'd4) begin
      n_bad++;
      $display("FAIL occ_bound: got %0d, want <= 4", occ);
    end
    hold_v = rst_n && !flush && (valid_out === 1'b1) && !ready;
    hold_d = {pc_out, instr_out};
  end

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    inj   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || ic_en !== 1'b0 || occ !== 3'd0 || ic_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b en=%b occ=%0d addr=%h, want 0 0 0 00000000",
               valid_out, ic_en, occ, ic_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 3) begin
        n_vec++;
        if (ic_en !== 1'b1 || ic_addr !== 32'(c * 4)) begin
          n_bad++;
          $display("FAIL stream_req c%0d: en=%b addr=%h, want 1 %h", c, ic_en, ic_addr, 32'(c * 4));
        end
      end
      n_vec++;
      if (valid_out !== (c >= 2)) begin
        n_bad++;
        $display("FAIL stream_valid c%0d: got %b, want %b", c, valid_out, (c >= 2));
      end
      if (c == 2) begin
        n_vec++;
        if (pc_out !== 32'h0 || instr_out !== XORK) begin
          n_bad++;
          $display("FAIL stream_first: pc=%h instr=%h, want 00000000 %h", pc_out, instr_out, XORK);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ic_en === 1'b1) nreq++;
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (nreq != 4 || occ !== 3'd4 || ic_en !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_fill: reqs=%0d occ=%0d en=%b, want 4 4 0", nreq, occ, ic_en);
    end
    n_vec++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin
      n_bad++;
      $display("FAIL bp_head: valid=%b pc=%h, want 1 00000000", valid_out, pc_out);
    end
    @(negedge clk);
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_vec++;
      if (valid_out !== 1'b1 || pc_out !== 32'(k * 4)) begin
        n_bad++;
        $display("FAIL bp_drain k%0d: valid=%b pc=%h, want 1 %h", k, valid_out, pc_out, 32'(k * 4));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    flush    = 1'b1;
    flush_pc = 32'h0000_0103;
    #1;
    n_vec++;
    if (occ !== 3'd3 || valid_out !== 1'b0 || ic_en !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_cycle: occ=%0d valid=%b en=%b, want 3 0 0", occ, valid_out, ic_en);
    end
    @(negedge clk);
    flush = 1'b0;
    ready = 1'b1;
    inj   = 1'b1;
    #1;
    n_vec++;
    if (ic_en !== 1'b1 || ic_addr !== 32'h100 || occ !== 3'd0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_redirect: en=%b addr=%h occ=%0d valid=%b, want 1 00000100 0 0",
               ic_en, ic_addr, occ, valid_out);
    end
    @(negedge clk);
    inj = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || occ !== 3'd0) begin
      n_bad++;
      $display("FAIL flush_stale_drop: valid=%b occ=%0d, want 0 0", valid_out, occ);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== (32'h100 ^ XORK)) begin
      n_bad++;
      $display("FAIL flush_first: valid=%b pc=%h instr=%h, want 1 00000100 %h",
               valid_out, pc_out, instr_out, 32'h100 ^ XORK);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_b2b();
    ready = 1'b1;
    repeat (3) @(negedge clk);
    flush    = 1'b1;
    flush_pc = 32'h200;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (ic_en !== 1'b0 || valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_flush k%0d: en=%b valid=%b, want 0 0", k, ic_en, valid_out);
      end
      @(negedge clk);
      flush_pc = 32'h300;
    end
    flush = 1'b0;
    #1;
    n_vec++;
    if (ic_en !== 1'b1 || ic_addr !== 32'h300) begin
      n_bad++;
      $display("FAIL b2b_req: en=%b addr=%h, want 1 00000300", ic_en, ic_addr);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (valid_out !== 1'b1 || pc_out !== 32'h300) begin
      n_bad++;
      $display("FAIL b2b_first: valid=%b pc=%h, want 1 00000300", valid_out, pc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] got [4];
    logic [31:0] want [4];
    int n;
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    want[3] = 32'h0000_0004;
    ready    = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (valid_out === 1'b1) begin
        got[n] = pc_out;
        n++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (n != 4) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d deliveries, want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (got[k] !== want[k]) begin
          n_bad++;
          $display("FAIL wrap_pc k%0d: got %h, want %h", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0 || ic_en !== 1'b0 || occ !== 3'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: valid=%b en=%b occ=%0d, want 0 0 0", valid_out, ic_en, occ);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (ic_en !== 1'b1 || ic_addr !== 32'h0 || occ !== 3'd0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_restart: en=%b addr=%h occ=%0d valid=%b, want 1 00000000 0 0",
               ic_en, ic_addr, occ, valid_out);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin
      n_bad++;
      $display("FAIL midrst_first: valid=%b pc=%h, want 1 00000000", valid_out, pc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_random_ready();
    int p0;
    p0 = pops;
    for (int c = 0; c < 1000; c++) begin
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_vec++;
    if (pops - p0 < 200) begin
      n_bad++;
      $display("FAIL random_progress: got %0d pops, want >= 200", pops - p0);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_b2b();
    test_wrap();
    test_reset_mid();
    test_random_ready();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
